// File: rtl/elevator_request_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_request_scheduler
//
// Request scheduler and car sequencer for the elevator. Floor calls arrive as
// a switch level (req_valid) plus a floor number (req_floor). Each rising edge
// of req_valid registers one call. Calls are held in a per-floor pending mask.
// The car serves them with a SCAN (directional-sweep) policy: it keeps moving
// in its current direction while calls remain ahead, and reverses only when
// nothing is left ahead. One shared timer paces both the floor-to-floor travel
// and the door dwell.
//
// Ports
//   clk        in   1  system clock, rising edge
//   reset_n    in   1  asynchronous, active-low reset
//   req_floor  in   3  requested floor
//   req_valid  in   1  call level; only its 0->1 transition registers a call
//   cur_floor  out  3  floor the car is at or last passed
//   pending    out  8  outstanding calls, one bit per floor
//   dir_up     out  1  sweep direction, 1 = up
//   moving     out  1  car is travelling between floors
//   door_open  out  1  door is open at cur_floor
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module elevator_request_scheduler #(
    parameter int SIMULATION   = 0,
    parameter int FLOORS       = 8,
    parameter int TRAVEL_TICKS = 50_000_000,
    parameter int DOOR_TICKS   = 100_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req_floor,
    input  logic       req_valid,
    output logic [2:0] cur_floor,
    output logic [7:0] pending,
    output logic       dir_up,
    output logic       moving,
    output logic       door_open
);

    // Short tick counts keep simulation runs fast.
    localparam int TRAVEL_EFF = (SIMULATION != 0) ? 4 : TRAVEL_TICKS;
    localparam int DOOR_EFF   = (SIMULATION != 0) ? 6 : DOOR_TICKS;
    localparam int MAX_TICKS  = (TRAVEL_EFF > DOOR_EFF) ? TRAVEL_EFF : DOOR_EFF;
    localparam int TW         = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_EFF - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_EFF - 1);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
    localparam logic [2:0]    TOP_FLOOR   = 3'(FLOORS - 1);
    localparam logic [3:0]    FLOOR_LIMIT = 4'(FLOORS);
    localparam logic [7:0]    FLOOR_MASK  = 8'((1 << FLOORS) - 1);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          req_d;
    logic [2:0]    floor_next;
    logic          dir_next;
    logic [2:0]    floor_up;
    logic [2:0]    floor_down;
    logic [7:0]    set_mask;
    logic [7:0]    clear_mask;
    logic          call;
    logic          call_here;
    logic          any_above;
    logic          any_below;
    logic          ahead;
    logic          behind;
    logic          at_rest;

    // -------------------------------------------------------------------------
    // Call detection and pending-mask classification
    // -------------------------------------------------------------------------
    always_comb begin
        // A call counts only on the switch's rising edge and only for a served floor.
        call      = req_valid && !req_d && ({1'b0, req_floor} < FLOOR_LIMIT);
        call_here = call && (req_floor == cur_floor);
        at_rest   = (state == IDLE) || (state == DOOR);

        // Masks strictly above / strictly below the current floor.
        any_above = |(pending & (8'hFE << cur_floor));
        any_below = |(pending & ~(8'hFF << cur_floor));
        ahead     = dir_up ? any_above : any_below;
        behind    = dir_up ? any_below : any_above;

        floor_up   = cur_floor + 3'd1;
        floor_down = cur_floor - 3'd1;

        // A call for the floor where the car stands still is served by the
        // door (open or reopen), so it never enters the pending mask. While
        // moving, the car has already left that floor, so it is queued.
        set_mask = '0;
        if (call && !(call_here && at_rest)) begin
            set_mask = 8'd1 << req_floor;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_next = state;
        timer_next = timer;
        floor_next = cur_floor;
        dir_next   = dir_up;
        clear_mask = '0;

        case (state)
            IDLE: begin
                timer_next = '0;
                if (call_here) begin
                    state_next = DOOR;
                end else if (pending != 8'd0) begin
                    // Keep the current sweep if it still has work; otherwise
                    // prefer down, and fall back to up.
                    if (dir_up && any_above) begin
                        state_next = MOVE_UP;
                    end else if (any_below) begin
                        state_next = MOVE_DOWN;
                        dir_next   = 1'b0;
                    end else begin
                        state_next = MOVE_UP;
                        dir_next   = 1'b1;
                    end
                end
            end

            MOVE_UP: begin
                if (timer != TRAVEL_LAST) begin
                    timer_next = timer + TIMER_ONE;
                end else begin
                    timer_next = '0;
                    if (cur_floor == TOP_FLOOR) begin
                        // Cannot go higher; let IDLE re-plan from here.
                        state_next = IDLE;
                    end else begin
                        floor_next = floor_up;
                        if (pending[floor_up]) begin
                            clear_mask = 8'd1 << floor_up;
                            state_next = DOOR;
                        end
                    end
                end
            end

            MOVE_DOWN: begin
                if (timer != TRAVEL_LAST) begin
                    timer_next = timer + TIMER_ONE;
                end else begin
                    timer_next = '0;
                    if (cur_floor == 3'd0) begin
                        state_next = IDLE;
                    end else begin
                        floor_next = floor_down;
                        if (pending[floor_down]) begin
                            clear_mask = 8'd1 << floor_down;
                            state_next = DOOR;
                        end
                    end
                end
            end

            DOOR: begin
                if (call_here) begin
                    // Someone pressed this floor again: hold the door longer.
                    timer_next = '0;
                end else if (timer != DOOR_LAST) begin
                    timer_next = timer + TIMER_ONE;
                end else begin
                    timer_next = '0;
                    if (ahead) begin
                        state_next = dir_up ? MOVE_UP : MOVE_DOWN;
                    end else if (behind) begin
                        dir_next   = !dir_up;
                        state_next = dir_up ? MOVE_DOWN : MOVE_UP;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= '0;
            req_d     <= 1'b0;
            cur_floor <= 3'd0;
            pending   <= 8'd0;
            dir_up    <= 1'b1;
            moving    <= 1'b0;
            door_open <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here samples the values from before this clock edge.
            state     <= state_next;
            timer     <= timer_next;
            req_d     <= req_valid;
            cur_floor <= floor_next;
            dir_up    <= dir_next;
            // Clear wins over set: an arrival at F also serves a call for F
            // that lands on the same edge.
            pending   <= (pending | set_mask) & ~clear_mask & FLOOR_MASK;
            moving    <= (state_next == MOVE_UP) || (state_next == MOVE_DOWN);
            door_open <= (state_next == DOOR);
        end
    end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// -----------------------------------------------------------------------------
// tb_elevator_request_scheduler
//
// Drives two scheduler instances from the same switch inputs: one serving all
// eight floors and one limited to six floors. A behavioural model of the car
// (floor number, call set, direction, and a cycles-remaining countdown) tracks
// each instance. Every output is compared on each falling clock edge. Directed
// scenarios come first, followed by randomized call traffic with occasional
// asynchronous resets.
// -----------------------------------------------------------------------------
module tb_elevator_request_scheduler;

    localparam int TRAVEL  = 4;
    localparam int DWELL   = 6;
    localparam int M_IDLE  = 0;
    localparam int M_MOVE  = 1;
    localparam int M_DOOR  = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] req_floor = 3'd0;
    logic       req_valid = 1'b0;

    logic [2:0] a_cur_floor;
    logic [7:0] a_pending;
    logic       a_dir_up;
    logic       a_moving;
    logic       a_door_open;

    logic [2:0] b_cur_floor;
    logic [7:0] b_pending;
    logic       b_dir_up;
    logic       b_moving;
    logic       b_door_open;

    elevator_request_scheduler #(
        .SIMULATION (1),
        .FLOORS     (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_floor (req_floor),
        .req_valid (req_valid),
        .cur_floor (a_cur_floor),
        .pending   (a_pending),
        .dir_up    (a_dir_up),
        .moving    (a_moving),
        .door_open (a_door_open)
    );

    elevator_request_scheduler #(
        .SIMULATION (1),
        .FLOORS     (6)
    ) dut6 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_floor (req_floor),
        .req_valid (req_valid),
        .cur_floor (b_cur_floor),
        .pending   (b_pending),
        .dir_up    (b_dir_up),
        .moving    (b_moving),
        .door_open (b_door_open)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, index 0 = eight floors, 1 = six floors.
    int         m_floor [2];
    logic [7:0] m_calls [2];
    bit         m_up    [2];
    int         m_mode  [2];
    int         m_left  [2];
    bit         m_prev;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int floors_of(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_floor[k] = 0;
            m_calls[k] = 8'd0;
            m_up[k]    = 1'b1;
            m_mode[k]  = M_IDLE;
            m_left[k]  = 0;
        end
        m_prev = 1'b0;
    endtask

    // One clock edge of the car, written from the operating rules.
    task automatic model_one(input int k, input bit acc, input int f);
        logic [7:0] snap;
        bit         above;
        bit         below;
        bit         here;
        bit         fwd;
        bit         back;
        int         fl;
        int         nf;
        snap  = m_calls[k];
        fl    = m_floor[k];
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (snap[i]) begin
                if (i > fl) above = 1'b1;
                if (i < fl) below = 1'b1;
            end
        end
        here = acc && (f == fl);
        if (acc && !(here && m_mode[k] != M_MOVE)) m_calls[k][f] = 1'b1;

        case (m_mode[k])
            M_IDLE: begin
                if (here) begin
                    m_mode[k] = M_DOOR;
                    m_left[k] = DWELL;
                end else if (snap != 8'd0) begin
                    if (!(m_up[k] && above)) m_up[k] = !below;
                    m_mode[k] = M_MOVE;
                    m_left[k] = TRAVEL;
                end
            end
            M_MOVE: begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_left[k] = TRAVEL;
                    nf = m_up[k] ? fl + 1 : fl - 1;
                    if (nf < 0 || nf >= floors_of(k)) begin
                        m_mode[k] = M_IDLE;
                    end else begin
                        m_floor[k] = nf;
                        if (snap[nf]) begin
                            m_calls[k][nf] = 1'b0;
                            m_mode[k] = M_DOOR;
                            m_left[k] = DWELL;
                        end
                    end
                end
            end
            default: begin
                if (here) begin
                    m_left[k] = DWELL;
                end else begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        fwd  = m_up[k] ? above : below;
                        back = m_up[k] ? below : above;
                        if (fwd) begin
                            m_mode[k] = M_MOVE;
                            m_left[k] = TRAVEL;
                        end else if (back) begin
                            m_up[k]   = !m_up[k];
                            m_mode[k] = M_MOVE;
                            m_left[k] = TRAVEL;
                        end else begin
                            m_mode[k] = M_IDLE;
                        end
                    end
                end
            end
        endcase
    endtask

    task automatic model_edge(input bit v, input int f);
        bit rise;
        rise = v && !m_prev;
        for (int k = 0; k < 2; k++) model_one(k, rise && (f < floors_of(k)), f);
        m_prev = v;
    endtask

    task automatic compare_all();
        check("a.cur_floor", {5'd0, a_cur_floor}, 8'(m_floor[0]));
        check("a.pending",   a_pending,           m_calls[0]);
        check("a.dir_up",    {7'd0, a_dir_up},    {7'd0, m_up[0]});
        check("a.moving",    {7'd0, a_moving},    {7'd0, m_mode[0] == M_MOVE});
        check("a.door_open", {7'd0, a_door_open}, {7'd0, m_mode[0] == M_DOOR});
        check("b.cur_floor", {5'd0, b_cur_floor}, 8'(m_floor[1]));
        check("b.pending",   b_pending,           m_calls[1]);
        check("b.dir_up",    {7'd0, b_dir_up},    {7'd0, m_up[1]});
        check("b.moving",    {7'd0, b_moving},    {7'd0, m_mode[1] == M_MOVE});
        check("b.door_open", {7'd0, b_door_open}, {7'd0, m_mode[1] == M_DOOR});
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge(req_valid, int'(req_floor));
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input int f);
        req_floor = 3'(f);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
    endtask

    // Asserted between clock edges; outputs must clear before the next edge.
    task automatic do_reset();
        #2;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        model_reset();
        #1;
        check("rst.cur_floor", {5'd0, a_cur_floor}, 8'd0);
        check("rst.pending",   a_pending,           8'd0);
        check("rst.dir_up",    {7'd0, a_dir_up},    8'd1);
        check("rst.moving",    {7'd0, a_moving},    8'd0);
        check("rst.door_open", {7'd0, a_door_open}, 8'd0);
        compare_all();
        ticks(2);
        reset_n = 1'b1;
    endtask

    task automatic wait_floor(input int target, input int limit);
        int i;
        i = 0;
        while (a_cur_floor != 3'(target) && i < limit) begin
            tick();
            i++;
        end
        check("wait_floor", {5'd0, a_cur_floor}, 8'(target));
    endtask

    task automatic wait_settle(input int limit);
        bit done;
        int i;
        i = 0;
        done = 1'b0;
        while (!done && i < limit) begin
            tick();
            i++;
            done = !a_moving && !a_door_open && (a_pending == 8'd0) &&
                   !b_moving && !b_door_open && (b_pending == 8'd0);
        end
        check("settle", {7'd0, done}, 8'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dcount;
        int mseen;
        int pseen;
        int stops[$];
        int exp_stops[3];
        bit prev_door;
        logic dir_at_zero;

        model_reset();
        ticks(2);
        reset_n = 1'b1;
        ticks(1);

        // Same-floor call while idle at floor 0: door only, no travel.
        dcount = 0; mseen = 0; pseen = 0;
        req_floor = 3'd0;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            req_valid = 1'b0;
            if (a_door_open) dcount++;
            if (a_moving) mseen++;
            if (a_pending != 8'd0) pseen++;
        end
        check("s2.door_cycles",  8'(dcount), 8'd6);
        check("s2.moving_seen",  8'(mseen),  8'd0);
        check("s2.pending_seen", 8'(pseen),  8'd0);

        // Call floor 3 from floor 0, accept edge = edge 0.
        req_floor = 3'd3;
        req_valid = 1'b1;
        tick();
        check("s1.pending_e0", a_pending, 8'h08);
        check("s1.moving_e0", {7'd0, a_moving}, 8'd0);
        req_valid = 1'b0;
        tick();
        check("s1.moving_e1", {7'd0, a_moving}, 8'd1);
        ticks(4);
        check("s1.floor_e5", {5'd0, a_cur_floor}, 8'd1);
        ticks(4);
        check("s1.floor_e9", {5'd0, a_cur_floor}, 8'd2);
        ticks(4);
        check("s1.floor_e13", {5'd0, a_cur_floor}, 8'd3);
        check("s1.door_e13", {7'd0, a_door_open}, 8'd1);
        check("s1.pending_e13", a_pending, 8'd0);
        check("s1.moving_e13", {7'd0, a_moving}, 8'd0);
        ticks(6);
        check("s1.door_e19", {7'd0, a_door_open}, 8'd0);
        check("s1.moving_e19", {7'd0, a_moving}, 8'd0);

        // Heading up to 6, calls for 4 then 0 while passing floor 1.
        do_reset();
        press(6);
        wait_floor(1, 20);
        press(4);
        press(0);
        prev_door   = 1'b0;
        dir_at_zero = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (a_door_open && !prev_door) begin
                stops.push_back(int'(a_cur_floor));
                if (a_cur_floor == 3'd0) dir_at_zero = a_dir_up;
            end
            prev_door = a_door_open;
            if (!a_moving && !a_door_open && a_pending == 8'd0 &&
                !b_moving && !b_door_open && b_pending == 8'd0) break;
        end
        exp_stops = '{4, 6, 0};
        check("s3.stop_count", 8'(stops.size()), 8'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("s3.stop%0d", i),
                  (i < stops.size()) ? 8'(stops[i]) : 8'hFF, 8'(exp_stops[i]));
        end
        check("s3.dir_at_floor0", {7'd0, dir_at_zero}, 8'd0);
        check("s3.pending_end", a_pending, 8'd0);

        // Held switch registers exactly one call.
        do_reset();
        req_floor = 3'd5;
        req_valid = 1'b1;
        tick();
        check("s4.pending_e0", a_pending, 8'h20);
        ticks(99);
        req_valid = 1'b0;
        wait_settle(50);
        check("s4.floor", {5'd0, a_cur_floor}, 8'd5);
        req_valid = 1'b1;
        tick();
        check("s4.reopen_door", {7'd0, a_door_open}, 8'd1);
        check("s4.reopen_pending", a_pending, 8'd0);
        req_valid = 1'b0;
        wait_settle(20);

        // Six-floor instance ignores floor 7.
        do_reset();
        press(7);
        check("s5.b_pending", b_pending, 8'd0);
        ticks(8);
        check("s5.b_moving", {7'd0, b_moving}, 8'd0);
        check("s5.b_door", {7'd0, b_door_open}, 8'd0);
        check("s5.b_pending_late", b_pending, 8'd0);
        wait_settle(100);

        // Reset mid-travel at floor 2 with calls for 2 and 7 outstanding.
        do_reset();
        press(7);
        wait_floor(2, 20);
        press(2);
        check("s6.pending", a_pending, 8'h84);
        check("s6.floor", {5'd0, a_cur_floor}, 8'd2);
        check("s6.moving", {7'd0, a_moving}, 8'd1);
        do_reset();

        // Random call traffic.
        for (int it = 0; it < 300; it++) begin
            int gap;
            int hold;
            gap  = $urandom_range(0, 20);
            hold = $urandom_range(1, 4);
            ticks(gap);
            if ($urandom_range(0, 9) == 0) ticks(60);
            if ($urandom_range(0, 49) == 0) do_reset();
            req_floor = 3'($urandom_range(0, 7));
            req_valid = 1'b1;
            ticks(hold);
            req_valid = 1'b0;
            tick();
        end
        wait_settle(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
